// File: rtl/day_cmp_pkg.sv
// day_cmp_pkg: shared FSM states, sizing helpers and
// {g,e,s} result encodings for the serial comparator.
package day_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_G    = 3'b100;
  localparam logic [2:0] RES_E    = 3'b010;
  localparam logic [2:0] RES_S    = 3'b001;

  function automatic int cmp_n(
    input int w,
    input int d
  );
    return w / d;
  endfunction

  function automatic int cmp_cw(
    input int w,
    input int d
  );
    return $clog2(w / d + 1);
  endfunction

endpackage

// File: rtl/day11_digit_comparator.sv
// day11_digit_comparator: combinational DIGIT-bit magnitude
// compare using MSB-first chained equality terms.
module day11_digit_comparator #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_g,
  output logic             o_e,
  output logic             o_s
);

  logic w_eq;
  logic w_g;
  logic w_s;

  always_comb begin
    w_eq = 1'b1;
    w_g  = 1'b0;
    w_s  = 1'b0;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      w_g  = w_g | (w_eq & i_a[i] & ~i_b[i]);
      w_s  = w_s | (w_eq & ~i_a[i] & i_b[i]);
      w_eq = w_eq & ~(i_a[i] ^ i_b[i]);
    end
  end

  assign o_g = w_g;
  assign o_e = w_eq;
  assign o_s = w_s;

endmodule

// File: rtl/day11_serial_comparator.sv
// day11_serial_comparator: MSB-first serial magnitude compare,
// DIGIT bits per cycle. CMP_EARLY_EXIT_EN: finish on first unequal digit.
module day11_serial_comparator
  import day_cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGIT  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             s
);

  localparam int N  = cmp_n(WIDTH, DIGIT);
  localparam int CW = cmp_cw(WIDTH, DIGIT);

  localparam logic [CW-1:0] LAST =
    CW'(N - 1);
  localparam logic [WIDTH-1:0] MSB =
    WIDTH'(1) << (WIDTH - 1);
  // offset-binary: flipping both MSBs turns signed order into unsigned
  localparam logic [WIDTH-1:0] FLIP =
    (SIGNED != 0) ? MSB : '0;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_dec;
  logic             r_dg;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_res;

  logic       w_g;
  logic       w_e;
  logic       w_s;
  logic       w_last;
  logic       w_exit;
  logic [2:0] w_res;

  day11_digit_comparator #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a (r_a[WIDTH-1 -: DIGIT]),
    .i_b (r_b[WIDTH-1 -: DIGIT]),
    .o_g (w_g),
    .o_e (w_e),
    .o_s (w_s)
  );

  assign w_last = (r_cnt == LAST);

`ifdef CMP_EARLY_EXIT_EN
  assign w_exit = w_last | ~w_e;
`else
  assign w_exit = w_last;
`endif

  always_comb begin
    w_res = RES_NONE;
    if (r_dec) begin
      w_res = r_dg ? RES_G : RES_S;
    end else begin
      w_res = {w_g, w_e, w_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      r_dg    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= RES_NONE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a ^ FLIP;
            r_b     <= b ^ FLIP;
            r_cnt   <= '0;
            r_dec   <= 1'b0;
            r_dg    <= 1'b0;
            r_res   <= RES_NONE;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a   <= r_a << DIGIT;
          r_b   <= r_b << DIGIT;
          r_cnt <= r_cnt + CW'(1);
          if (!r_dec && !w_e) begin
            r_dec <= 1'b1;
            r_dg  <= w_g;
          end
          if (w_exit) begin
            r_res   <= w_res;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign g    = r_res[2];
  assign e    = r_res[1];
  assign s    = r_res[0];

endmodule

// File: tb/tb_day11_serial_comparator.sv
// tb_day11_serial_comparator: random and directed stimulus into three
// comparator configurations, checked by a queue scoreboard.
module tb_day11_serial_comparator;

  typedef struct {
    logic [2:0] res;
    int         acc;
    int         dcyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;

  logic busy0, done0, g0, e0, s0;
  logic busy1, done1, g1, e1, s1;
  logic busy2, done2, g2, e2, s2;

  int cyc;
  int nchk;
  int nerr;
  bit mon_en;

  int W [3] = '{16, 16, 8};
  int D [3] = '{4, 4, 1};
  int SG[3] = '{0, 1, 1};

  int last_acc[3];
  int last_lat[3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  day11_serial_comparator #(
    .WIDTH(16), .DIGIT(4), .SIGNED(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy0), .done(done0),
    .g(g0), .e(e0), .s(s0)
  );

  day11_serial_comparator #(
    .WIDTH(16), .DIGIT(4), .SIGNED(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy1), .done(done1),
    .g(g1), .e(e1), .s(s1)
  );

  day11_serial_comparator #(
    .WIDTH(8), .DIGIT(1), .SIGNED(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a[7:0]), .b(b[7:0]), .busy(busy2), .done(done2),
    .g(g2), .e(e2), .s(s2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] ref_res(
    input logic [15:0] va, input logic [15:0] vb,
    input int w, input int sg
  );
    int ia;
    int ib;
    ia = int'(va) & ((1 << w) - 1);
    ib = int'(vb) & ((1 << w) - 1);
    if (sg != 0 && ia >= (1 << (w - 1))) ia -= (1 << w);
    if (sg != 0 && ib >= (1 << (w - 1))) ib -= (1 << w);
    if (ia > ib) return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_lat(
    input logic [15:0] va, input logic [15:0] vb,
    input int w, input int d
  );
    int n;
    n = w / d;
`ifdef CMP_EARLY_EXIT_EN
    for (int k = 1; k <= n; k++) begin
      int sh;
      int m;
      sh = w - k * d;
      m  = (1 << d) - 1;
      if (((int'(va) >> sh) & m) != ((int'(vb) >> sh) & m))
        return k + 1;
    end
`endif
    return n + 1;
  endfunction

  function automatic int qsz(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfr(input int id);
    case (id)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int id, input exp_t x);
    case (id)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic qpop(input int id);
    case (id)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic chk(
    input string nm, input int id,
    input logic [31:0] got, input logic [31:0] want
  );
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0h want %0h (cyc %0d)",
               nm, id, got, want, cyc);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 0, {busy0, done0, g0, e0, s0}, 0);
    chk(nm, 1, {busy1, done1, g1, e1, s1}, 0);
    chk(nm, 2, {busy2, done2, g2, e2, s2}, 0);
  endtask

  task automatic mon(
    input int id, input logic bz, input logic dn,
    input logic [2:0] res
  );
    exp_t f;
    bit   have;
    bit   bexp;
    f    = '{res: 3'b000, acc: 0, dcyc: 0};
    have = qsz(id) > 0;
    if (have) f = qfr(id);
    bexp = have && cyc > f.acc && cyc < f.dcyc;
    chk("busy", id, 32'(bz), 32'(bexp));
    if (dn) begin
      if (!have) begin
        chk("spurious_done", id, 1, 0);
      end else begin
        chk("done_cycle", id, cyc, f.dcyc);
        chk("result", id, 32'(res), 32'(f.res));
        chk("onehot", id, 32'($onehot(res)), 1);
        qpop(id);
      end
    end else if (have && cyc >= f.dcyc) begin
      chk("missing_done", id, 0, 1);
      qpop(id);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon(0, busy0, done0, {g0, e0, s0});
      mon(1, busy1, done1, {g1, e1, s1});
      mon(2, busy2, done2, {g2, e2, s2});
    end
  end

  task automatic drive(
    input bit st, input logic [15:0] va, input logic [15:0] vb
  );
    @(negedge clk);
    start = st;
    a     = va;
    b     = vb;
    if (st) begin
      for (int id = 0; id < 3; id++) begin
        if (cyc >= last_acc[id] + last_lat[id]) begin
          exp_t x;
          int   lat;
          lat    = ref_lat(va, vb, W[id], D[id]);
          x.res  = ref_res(va, vb, W[id], SG[id]);
          x.acc  = cyc;
          x.dcyc = cyc + lat;
          qpush(id, x);
          last_acc[id] = cyc;
          last_lat[id] = lat;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, a, b);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int id = 0; id < 3; id++) begin
      last_acc[id] = -100;
      last_lat[id] = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] va;
    logic [15:0] vb;
    bit          st;
    nchk   = 0;
    nerr   = 0;
    mon_en = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    model_reset();
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_state");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    drive(1'b1, 16'h1234, 16'h1234); idle(12);
    drive(1'b1, 16'h8000, 16'h7FFF); idle(12);
    drive(1'b1, 16'h1235, 16'h1234); idle(12);
    drive(1'b1, 16'h00FF, 16'h0001); idle(12);
    drive(1'b1, 16'h0000, 16'hFFFF); idle(12);
    drive(1'b1, 16'h7F80, 16'h7F80); idle(12);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) drive(1'b1, 16'hFFFF, 16'h0000);
      else            drive(1'b1, 16'h1234, 16'h4321);
    end
    idle(12);

    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 2) == 0);
      va = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       vb = va;
        1:       vb = va ^ (16'h1 << $urandom_range(0, 15));
        default: vb = 16'($urandom);
      endcase
      drive(st, va, vb);
    end
    idle(12);

    drive(1'b1, 16'h1234, 16'h1243);
    idle(2);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrun_reset");
    model_reset();
    @(negedge clk);
    #1 chk_zero("held_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 16'hABCD, 16'hABCC); idle(12);

    for (int id = 0; id < 3; id++) chk("drain", id, qsz(id), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/day11_serial_comparator.md
# day11_serial_comparator

Parametrised sequential magnitude comparator producing the same greater/equal/smaller flags as the combinational 4-bit comparator, extended to arbitrary operand width. It evaluates DIGIT bits per cycle, MSB-first, and supports a signed mode and a start/busy/done handshake. It sits beside the combinational comparators in the code-converter group, for wide operands where a single-cycle ripple of equality terms does not meet timing.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only when not busy.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- busy  output  1  compare in progress; start ignored.
- done  output  1  one-cycle pulse; g/e/s valid from this cycle.
- g  output  1  a > b.
- e  output  1  a == b.
- s  output  1  a < b.

## Operation
- N = WIDTH/DIGIT digits. FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, capture a and b into internal shift registers, clear the digit counter and decided flag, and go to RUN. If SIGNED=1, invert the MSB of both captured operands (offset-binary), so unsigned digit compare yields signed order.
- RUN: each cycle compares the top DIGIT bits of both registers, then shifts both left by DIGIT. The first unequal digit latches g/s (decided); later digits cannot change a decided result. Counter increments; after digit N-1 the FSM goes to DONE. If no digit differed, e=1.
- DONE: lasts exactly one cycle with done=1; returns to IDLE. A start in DONE is accepted (back-to-back: captures and goes to RUN).
- g/e/s hold their last result through IDLE until the next accepted start. On accepted start they clear to 0 and stay 0 until done.
- Exactly one of g/e/s is 1 whenever done=1.
- start while busy=1 is ignored, not queued; a/b changes while busy have no effect.
- Reset (any time, including mid-RUN): state IDLE, busy=0, done=0, g=0, e=0, s=0, counter 0; the in-flight compare is discarded, with no done.

## Timing
- busy=1 in RUN only; it goes high the cycle after start is sampled.
- Start sampled at edge 0. Digits are processed on edges 1..N. done=1 and results are valid in the cycle following edge N: a latency of N+1 cycles from start to done.
- Throughput: one compare per N+1 cycles with back-to-back start in DONE.
- DIGIT=WIDTH gives N=1, with latency 2.

## Configuration
- CMP_EARLY_EXIT_EN defined: in RUN, when the current digit is unequal, the FSM goes to DONE after that edge. Latency is k+1 cycles, where k is the 1-based index (from MSB) of the first unequal digit. Equal operands still take N+1.
- Not defined: latency is always N+1, independent of the data.

## Structure
- Shared package day_cmp_pkg: state enum (IDLE, RUN, DONE); localparam function for N and for counter width $clog2(N+1); result encoding constants for {g,e,s}.
- Sub-module day11_digit_comparator: combinational DIGIT-bit compare producing g/e/s with the same equality-chained logic as the 4-bit comparator, generalised by parameter DIGIT. It is instantiated once and reused each cycle.

## Test plan
- WIDTH=16, DIGIT=4, unsigned; a=0x1234, b=0x1234 -> done at start+5 cycles, e=1, g=s=0.
- a=0x8000, b=0x7FFF, unsigned -> g=1. With SIGNED=1 the same operands -> s=1. With CMP_EARLY_EXIT_EN, done at start+2.
- a=0x1235, b=0x1234 -> g=1. Done at start+5 both with and without CMP_EARLY_EXIT_EN (last digit decides).
- start held high continuously with alternating operands -> done pulses every 5 cycles (no macro). Start pulses during busy are ignored, and a/b changes mid-RUN do not alter the result.
- Assert rst_n=0 at RUN digit 2 -> all outputs 0 immediately, no done. A fresh start after release completes normally.
- DIGIT=1, WIDTH=8, SIGNED=1; a=0xFF (-1), b=0x01 -> s=1, done at start+9.
